// File: rtl/parking_gate_arbiter.sv
// Parking gate sequencing controller.
// Synchronises the entry and exit sensors and keeps one pending request per side.
// Requests are arbitrated only while the gate is idle. On an entry the car gets the
// lowest free slot, and on an exit the selected slot is freed. The controller times
// the door-open and lot-full lights and owns the 4-bit slot occupancy register.
module parking_gate_arbiter #(
    parameter int DOOR_CYCLES = 80000000,
    parameter int FULL_CYCLES = 40000000,
    parameter int CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] exit_slot,
    output logic [3:0] parking_slots,
    output logic       door_open_light,
    output logic       full_light,
    output logic       err_light,
    output logic       busy,
    output logic [1:0] assigned_slot
);

    // Gate sequencing states
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ENTRY_OPEN = 2'd1;
    localparam logic [1:0] EXIT_OPEN  = 2'd2;
    localparam logic [1:0] DENY_FULL  = 2'd3;

    // Timer reload values: a light stays on for load+1 cycles
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(FULL_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       exit_latched;
    logic             prio_exit;      // 0: entry wins the next tie, 1: exit wins

    logic             entry_meta, entry_sync, entry_prev;
    logic             exit_meta,  exit_sync,  exit_prev;
    logic             entry_rise, exit_rise;
    logic             pend_entry, pend_exit;

    logic             serve_entry, serve_exit, tie;
    logic             lot_full;
    logic [1:0]       free_slot;
    logic             timer_done;

    // Two-flop synchronisers plus an edge-history flop for both sensor pins.
    // NOTE: these flops are deliberately left out of reset. They keep tracking the
    // pins through a reset, so a sensor that is still held high when reset releases
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        entry_meta <= entry_sensor;
        entry_sync <= entry_meta;
        entry_prev <= entry_sync;
        exit_meta  <= exit_sensor;
        exit_sync  <= exit_meta;
        exit_prev  <= exit_sync;
    end

    assign entry_rise = entry_sync & ~entry_prev;
    assign exit_rise  = exit_sync  & ~exit_prev;

    // One-deep request flags: a flag is set on a rising edge and cleared when its
    // request is served. Edges that arrive while the flag is already set are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_entry <= 1'b0;
            pend_exit  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments. Every flop then
            // samples the values from before this edge, whatever the block order.
            pend_entry <= serve_entry ? 1'b0 : (pend_entry | entry_rise);
            pend_exit  <= serve_exit  ? 1'b0 : (pend_exit  | exit_rise);
        end
    end

    // Lowest-index free slot. Its value is ignored when the lot is full.
    always_comb begin
        // NOTE: this default comes before the loop, so free_slot is assigned on
        // every path and no latch is inferred.
        free_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!parking_slots[i]) begin
                free_slot = 2'(i);
            end
        end
    end

    assign lot_full   = &parking_slots;
    assign timer_done = (timer == '0);

    // Arbitration happens only in IDLE. A tie goes to the side named by the pointer.
    always_comb begin
        serve_entry = 1'b0;
        serve_exit  = 1'b0;
        tie         = 1'b0;
        if (state == IDLE) begin
            if (pend_entry && pend_exit) begin
                tie = 1'b1;
                if (prio_exit) begin
                    serve_exit = 1'b1;
                end else begin
                    serve_entry = 1'b1;
                end
            end else if (pend_entry) begin
                serve_entry = 1'b1;
            end else if (pend_exit) begin
                serve_exit = 1'b1;
            end
        end
    end

    // Tie-break pointer: it flips only when both sides were waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_exit <= 1'b0;
        end else if (tie) begin
            prio_exit <= ~prio_exit;
        end
    end

    // Gate FSM: grants and denials, light timing, and occupancy commits on close.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            exit_latched    <= 2'd0;
            assigned_slot   <= 2'd0;
            parking_slots   <= 4'b0000;
            door_open_light <= 1'b0;
            full_light      <= 1'b0;
            err_light       <= 1'b0;
        end else begin
            err_light <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve_entry) begin
                        if (lot_full) begin
                            state      <= DENY_FULL;
                            full_light <= 1'b1;
                            timer      <= FULL_LOAD;
                        end else begin
                            state           <= ENTRY_OPEN;
                            assigned_slot   <= free_slot;
                            door_open_light <= 1'b1;
                            timer           <= DOOR_LOAD;
                        end
                    end else if (serve_exit) begin
                        if (parking_slots[exit_slot]) begin
                            state           <= EXIT_OPEN;
                            exit_latched    <= exit_slot;
                            door_open_light <= 1'b1;
                            timer           <= DOOR_LOAD;
                        end else begin
                            // The selected slot is empty: refuse with a one-cycle pulse
                            err_light <= 1'b1;
                        end
                    end
                end

                ENTRY_OPEN: begin
                    if (timer_done) begin
                        state                        <= IDLE;
                        door_open_light              <= 1'b0;
                        parking_slots[assigned_slot] <= 1'b1;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                EXIT_OPEN: begin
                    if (timer_done) begin
                        state                       <= IDLE;
                        door_open_light             <= 1'b0;
                        parking_slots[exit_latched] <= 1'b0;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                DENY_FULL: begin
                    if (timer_done) begin
                        state      <= IDLE;
                        full_light <= 1'b0;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter (door 8 cycles, full warning 5 cycles).
module tb_parking_gate_arbiter;

    localparam int DOOR = 8;
    localparam int FULL = 5;

    logic       clk;
    logic       rst_n;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] exit_slot;
    logic [3:0] parking_slots;
    logic       door_open_light;
    logic       full_light;
    logic       err_light;
    logic       busy;
    logic [1:0] assigned_slot;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    parking_gate_arbiter #(
        .DOOR_CYCLES(DOOR),
        .FULL_CYCLES(FULL),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entry_sensor   (entry_sensor),
        .exit_sensor    (exit_sensor),
        .exit_slot      (exit_slot),
        .parking_slots  (parking_slots),
        .door_open_light(door_open_light),
        .full_light     (full_light),
        .err_light      (err_light),
        .busy           (busy),
        .assigned_slot  (assigned_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the gate.
    // kind: 0 idle, 1 entry passage, 2 exit passage, 3 full warning.
    // left: number of cycles the current light is still due to stay on.
    bit        hist_e[3];
    bit        hist_x[3];
    bit        m_occ[4];
    int        m_kind = 0;
    int        m_left = 0;
    int        m_assigned = 0;
    int        m_exit = 0;
    bit        m_prio_exit = 1'b0;
    bit        m_pend_e = 1'b0;
    bit        m_pend_x = 1'b0;
    bit        m_err = 1'b0;

    function automatic logic [3:0] model_slots();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_occ[i];
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit rise_e, rise_x, serve_e, serve_x, full;
        // A pin edge becomes a pending request on the third clock after it is first sampled
        rise_e = hist_e[1] && !hist_e[2];
        rise_x = hist_x[1] && !hist_x[2];
        hist_e[2] = hist_e[1]; hist_e[1] = hist_e[0]; hist_e[0] = entry_sensor;
        hist_x[2] = hist_x[1]; hist_x[1] = hist_x[0]; hist_x[0] = exit_sensor;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
            m_kind = 0; m_left = 0; m_assigned = 0; m_exit = 0;
            m_prio_exit = 1'b0; m_pend_e = 1'b0; m_pend_x = 1'b0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            serve_e = 1'b0;
            serve_x = 1'b0;
            if (m_kind != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_kind == 1) m_occ[m_assigned] = 1'b1;
                    if (m_kind == 2) m_occ[m_exit] = 1'b0;
                    m_kind = 0;
                end
            end else begin
                if (m_pend_e && m_pend_x) begin
                    if (m_prio_exit) serve_x = 1'b1; else serve_e = 1'b1;
                    m_prio_exit = !m_prio_exit;
                end else if (m_pend_e) begin
                    serve_e = 1'b1;
                end else if (m_pend_x) begin
                    serve_x = 1'b1;
                end
                if (serve_e) begin
                    full = m_occ[0] && m_occ[1] && m_occ[2] && m_occ[3];
                    if (full) begin
                        m_kind = 3; m_left = FULL;
                    end else begin
                        for (int i = 3; i >= 0; i--) if (!m_occ[i]) m_assigned = i;
                        m_kind = 1; m_left = DOOR;
                    end
                end
                if (serve_x) begin
                    if (m_occ[exit_slot]) begin
                        m_exit = int'(exit_slot); m_kind = 2; m_left = DOOR;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            m_pend_e = serve_e ? 1'b0 : (m_pend_e | rise_e);
            m_pend_x = serve_x ? 1'b0 : (m_pend_x | rise_x);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_slots", parking_slots, model_slots());
            check("cmp_door", door_open_light, (m_kind == 1 || m_kind == 2));
            check("cmp_full", full_light, (m_kind == 3));
            check("cmp_err", err_light, m_err);
            check("cmp_busy", busy, (m_kind != 0));
            check("cmp_assigned", assigned_slot, m_assigned);
        end
    end

    // Pulse the sensors for one cycle, then watch the outputs for 40 cycles.
    // Index 0 is the first negedge after the second clock edge following the pulse.
    task automatic txn(input bit e, input bit x, input logic [1:0] slot,
                       output int dn, output int fn, output int en,
                       output int d_first, output int e_first);
        @(negedge clk);
        entry_sensor = e;
        exit_sensor  = x;
        exit_slot    = slot;
        @(negedge clk);
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        dn = 0; fn = 0; en = 0; d_first = -1; e_first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (door_open_light) begin
                dn++;
                if (d_first < 0) d_first = i;
            end
            if (full_light) fn++;
            if (err_light) begin
                en++;
                if (e_first < 0) e_first = i;
            end
        end
    endtask

    initial begin
        int dn, fn, en, df, ef, got;
        rst_n        = 1'b0;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        exit_slot    = 2'd0;
        repeat (4) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_slots", parking_slots, 4'b0000);
        check("reset_door", door_open_light, 1'b0);
        check("reset_full", full_light, 1'b0);
        check("reset_err", err_light, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_assigned", assigned_slot, 2'd0);
        rst_n = 1'b1;

        // First entry: door rises 4 clocks after the pin edge and stays up 8 cycles
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("t1_door_first", df, 2);
        check("t1_door_len", dn, DOOR);
        check("t1_slots", parking_slots, 4'b0001);
        check("t1_assigned", assigned_slot, 2'd0);
        check("t1_busy", busy, 1'b0);

        // Fill the lot
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("fill2_slots", parking_slots, 4'b0011);
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("fill3_slots", parking_slots, 4'b0111);
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("fill4_slots", parking_slots, 4'b1111);
        check("fill4_assigned", assigned_slot, 2'd3);

        // Fifth entry is refused
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("deny_full_len", fn, FULL);
        check("deny_door_len", dn, 0);
        check("deny_slots", parking_slots, 4'b1111);

        // Build 4'b1011, then exit an empty slot, then a taken one
        txn(1'b0, 1'b1, 2'd2, dn, fn, en, df, ef);
        check("exit2_slots", parking_slots, 4'b1011);
        txn(1'b0, 1'b1, 2'd2, dn, fn, en, df, ef);
        check("err_pulse_len", en, 1);
        check("err_door_len", dn, 0);
        check("err_slots", parking_slots, 4'b1011);
        txn(1'b0, 1'b1, 2'd1, dn, fn, en, df, ef);
        check("exit1_door_len", dn, DOOR);
        check("exit1_slots", parking_slots, 4'b1001);
        txn(1'b0, 1'b1, 2'd3, dn, fn, en, df, ef);
        check("exit3_slots", parking_slots, 4'b0001);

        // Tie with the pointer on entry: entry (slot 1) first, exit of slot 0 one cycle after close
        txn(1'b1, 1'b1, 2'd0, dn, fn, en, df, ef);
        check("tie1_door_first", df, 2);
        check("tie1_door_len", dn, 2 * DOOR);
        check("tie1_slots", parking_slots, 4'b0010);

        // Next tie serves the exit first: slot 0 is empty, so err comes before the door
        txn(1'b1, 1'b1, 2'd0, dn, fn, en, df, ef);
        check("tie2_err_first", ef, 2);
        check("tie2_door_first", df, 3);
        check("tie2_slots", parking_slots, 4'b0011);
        check("tie2_assigned", assigned_slot, 2'd0);

        // Full lot, tie with the pointer back on entry: deny first, then exit frees slot 3
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("refill_slots", parking_slots, 4'b1111);
        txn(1'b1, 1'b1, 2'd3, dn, fn, en, df, ef);
        check("tie3_full_len", fn, FULL);
        check("tie3_door_len", dn, DOOR);
        check("tie3_slots", parking_slots, 4'b0111);
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("after_tie3_assigned", assigned_slot, 2'd3);
        check("after_tie3_slots", parking_slots, 4'b1111);
        txn(1'b0, 1'b1, 2'd1, dn, fn, en, df, ef);
        check("free1_slots", parking_slots, 4'b1101);

        // Reset in the middle of an entry passage, with the sensor held high
        @(negedge clk);
        entry_sensor = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (door_open_light) got = 1;
        end
        check("midrst_door_rose", got, 1);
        check("midrst_assigned", assigned_slot, 2'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_slots", parking_slots, 4'b0000);
        check("midrst_door", door_open_light, 1'b0);
        check("midrst_full", full_light, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_assigned_clr", assigned_slot, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (door_open_light || busy) got++;
        end
        check("held_no_grant", got, 0);
        check("held_slots", parking_slots, 4'b0000);
        entry_sensor = 1'b0;
        repeat (3) @(negedge clk);
        txn(1'b1, 1'b0, 2'd0, dn, fn, en, df, ef);
        check("post_rst_door_first", df, 2);
        check("post_rst_slots", parking_slots, 4'b0001);
        check("post_rst_assigned", assigned_slot, 2'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
Sequencing controller for the shared parking gate. It arbitrates entry and exit requests, allocates the lowest free slot on entry, and frees the selected slot on exit. It times the door-open and full-warning indications and owns the 4-bit slot occupancy register that feeds the capacity/location encoders and the seven-segment path. It runs in the 40 MHz domain, downstream of the frequency divider.

Parameters:
DOOR_CYCLES, 80000000, clk cycles door_open_light stays high per granted passage (2 s at 40 MHz)
FULL_CYCLES, 40000000, clk cycles full_light stays high after a denied entry (1 s)
CNT_W, 27, timer width; must hold max(DOOR_CYCLES, FULL_CYCLES)

Ports:
clk  input  1  system clock, 40 MHz
rst_n  input  1  synchronous active-low reset
entry_sensor  input  1  async level, car at entry
exit_sensor  input  1  async level, car at exit
exit_slot  input  2  slot index of leaving car (switch), sampled at exit grant
parking_slots  output  4  occupancy, bit i = slot i taken
door_open_light  output  1  gate open
full_light  output  1  entry refused, lot full
err_light  output  1  exit refused, selected slot empty; one-cycle pulse
busy  output  1  FSM not in IDLE
assigned_slot  output  2  slot granted to last entry; valid while door open on entry

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs 0, FSM=IDLE, timer=0, pending flags=0, priority pointer=ENTRY. Reset mid-passage aborts the passage; no slot is committed or freed.
- Inputs pass through a 2-flop synchroniser, then rising-edge detect. Request latency: edge on pin -> pend flag set 3 clk later.
- pend_entry/pend_exit: set on the synchronised rising edge, cleared when that request is granted or denied. Depth is one; further edges while a flag is set are dropped.
- Arbitration happens in IDLE only. If one flag is set, serve it. If both are set, serve the side the priority pointer selects, then toggle the pointer so the other side wins the next tie. The pointer toggles only on a tie.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN, DENY_FULL.
- IDLE, entry chosen, parking_slots != 4'b1111: go to ENTRY_OPEN. assigned_slot = lowest index with parking_slots[i]=0. door_open_light=1. timer loads DOOR_CYCLES-1.
- IDLE, entry chosen, parking_slots == 4'b1111: go to DENY_FULL. full_light=1. timer loads FULL_CYCLES-1.
- IDLE, exit chosen, parking_slots[exit_slot]=1: go to EXIT_OPEN. Latch exit_slot. door_open_light=1. timer loads DOOR_CYCLES-1.
- IDLE, exit chosen, parking_slots[exit_slot]=0: err_light pulses for 1 cycle, pend_exit clears, FSM stays in IDLE.
- Open and deny states: timer decrements each clk. When timer==0, go to IDLE next edge and drop door_open_light/full_light on that edge. Each light is high exactly DOOR_CYCLES (or FULL_CYCLES) cycles.
- Commit on leaving ENTRY_OPEN: parking_slots[assigned_slot] <= 1. Commit on leaving EXIT_OPEN: parking_slots[latched slot] <= 0. Occupancy changes only on these two transitions.
- Entry and exit flags both set while the lot is full: the exit still gets its grant. An entry that arrives after the exit commit is allocated normally.
- busy=1 in every state except IDLE. A request can be granted in the first IDLE cycle after return, so back-to-back passages have a 1-cycle gap.
- No arithmetic overflow: the timer never counts below 0, and slot indices are 2-bit exact.

Test Plan:
- Reset, then entry edge: door_open_light rises 4 clk after pin edge (3 sync + 1 grant) with DOOR_CYCLES=8 override. High 8 cycles, assigned_slot=0, then parking_slots=4'b0001, busy=0.
- Four sequential entries, then a fifth: parking_slots=4'b1111. Fifth gives full_light high FULL_CYCLES (=5) cycles, door stays 0, occupancy unchanged.
- parking_slots=4'b1011, exit_slot=2: err_light 1-cycle pulse, no door, occupancy unchanged. Then exit_slot=1: door opens, parking_slots=4'b1001 after close.
- Entry and exit edges in the same cycle, slots 4'b0001, exit_slot=0: entry served first (pointer=ENTRY), then exit 1 cycle after close. Next tie serves exit first.
- Lot full, exit and entry edges simultaneous, pointer=ENTRY: entry denied (full_light), then exit frees slot 3 → 4'b0111. A following entry is assigned slot 3.
- rst_n low mid ENTRY_OPEN at timer=3: next edge all outputs 0, occupancy 0, pend flags cleared. A sensor still held high gives no grant until a new rising edge.
